// File: rtl/tick_bcd_counter_if.sv
// tick_bcd_counter_if
//   Bundles the control strobes and the BCD display outputs of
//   tick_bcd_counter. Clock and reset stay as plain ports on the block.
//
//   Signals
//     iTick   time-base strobe, one 1-cycle pulse per second
//     iStart  start/resume request, single-cycle pulse
//     iStop   pause request, single-cycle pulse
//     iClear  clear-to-zero request, single-cycle pulse
//     oSecU   seconds units, BCD 0..9
//     oSecT   seconds tens,  BCD 0..5
//     oMinU   minutes units, BCD 0..9
//     oMinT   minutes tens,  BCD 0..9
//     oRun    high while the counter is running
//     oWrap   one-cycle pulse on MIN_MAX:59 -> 00:00
//
//   master : the side that issues requests and reads the display
//   slave  : the counter itself
interface tick_bcd_counter_if;
    logic       iTick;
    logic       iStart;
    logic       iStop;
    logic       iClear;
    logic [3:0] oSecU;
    logic [3:0] oSecT;
    logic [3:0] oMinU;
    logic [3:0] oMinT;
    logic       oRun;
    logic       oWrap;

    modport master (
        output iTick, iStart, iStop, iClear,
        input  oSecU, oSecT, oMinU, oMinT, oRun, oWrap
    );

    modport slave (
        input  iTick, iStart, iStop, iClear,
        output oSecU, oSecT, oMinU, oMinT, oRun, oWrap
    );
endinterface

// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter
//   Minutes:seconds stopwatch counting in BCD. A small IDLE/RUN/PAUSE
//   state machine gates the once-per-second iTick strobe into a 4-digit
//   BCD counter that wraps from MIN_MAX:59 back to 00:00 with a
//   one-cycle oWrap pulse. All outputs are registered.
//
//   Parameters
//     MIN_MAX  highest minutes value before wrap (1..99), default 59
//
//   Ports
//     iclk     clock, all state changes on its rising edge
//     irst_n   asynchronous active-low reset
//     bus      tick_bcd_counter_if.slave (strobes in, BCD digits/status out)
//
//   Build option
//     TICK_EDGE_DET_EN  when defined, iTick is registered and only its
//                       0->1 transition produces a count event (one extra
//                       cycle of latency; a held-high iTick counts once).
//                       When undefined, every RUN cycle with iTick high counts.
module tick_bcd_counter #(
    parameter int MIN_MAX = 59
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    tick_bcd_counter_if.slave    bus
);

    localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_U = 4'(MIN_MAX % 10);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t      state;
    // packed as {min_t, min_u, sec_t, sec_u}
    logic [15:0] digits;
    logic        run;
    logic        wrap;
    logic        count_evt;
    logic        at_max;

    // BCD increment across the four digits; the wrap case is handled by
    // the caller, so minutes tens never exceeds 9 here.
    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = d;
        if (su != 4'd9) begin
            su = su + 4'd1;
        end else begin
            su = 4'd0;
            if (st != 4'd5) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if (mu != 4'd9) begin
                    mu = mu + 4'd1;
                end else begin
                    mu = 4'd0;
                    mt = mt + 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

`ifdef TICK_EDGE_DET_EN
    logic tick_prev;
    logic edge_evt;

    // Rising-edge detect registered once more so the event is a clean
    // one-cycle pulse independent of how long iTick stays high.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            tick_prev <= 1'b0;
            edge_evt  <= 1'b0;
        end else begin
            tick_prev <= bus.iTick;
            edge_evt  <= bus.iTick & ~tick_prev;
        end
    end

    assign count_evt = edge_evt;
`else
    assign count_evt = bus.iTick;
`endif

    assign at_max = (digits == {MAX_T, MAX_U, 4'd5, 4'd9});

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state  <= IDLE;
            digits <= 16'h0000;
            run    <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    // iClear and iStop both outrank iStart
                    if (!bus.iClear && !bus.iStop && bus.iStart) begin
                        state <= RUN;
                        run   <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.iClear) begin
                        state  <= IDLE;
                        run    <= 1'b0;
                        digits <= 16'h0000;
                    end else begin
                        // A tick arriving with iStop is still counted.
                        if (count_evt) begin
                            if (at_max) begin
                                digits <= 16'h0000;
                                wrap   <= 1'b1;
                            end else begin
                                digits <= bcd_inc(digits);
                            end
                        end
                        if (bus.iStop) begin
                            state <= PAUSE;
                            run   <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.iClear) begin
                        state  <= IDLE;
                        digits <= 16'h0000;
                    end else if (!bus.iStop && bus.iStart) begin
                        state <= RUN;
                        run   <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    run    <= 1'b0;
                    digits <= 16'h0000;
                end
            endcase
        end
    end

    assign bus.oMinT = digits[15:12];
    assign bus.oMinU = digits[11:8];
    assign bus.oSecT = digits[7:4];
    assign bus.oSecU = digits[3:0];
    assign bus.oRun  = run;
    assign bus.oWrap = wrap;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// tb_tick_bcd_counter
//   Bench for tick_bcd_counter (MIN_MAX = 59). A reference model keeps the
//   elapsed time as a plain seconds total plus a run/pause/idle mode and
//   derives the expected BCD digits arithmetically. Directed scenarios
//   cover the documented cases, followed by randomized strobes with
//   occasional asynchronous resets.
module tb_tick_bcd_counter;

    localparam int MIN_MAX = 59;
    localparam int LIMIT   = (MIN_MAX + 1) * 60;

    logic iclk;
    logic irst_n;

    tick_bcd_counter_if bus ();

    tick_bcd_counter #(.MIN_MAX(MIN_MAX)) dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .bus    (bus)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int n_checks;
    int n_errors;

    // reference model state
    int total;      // elapsed seconds, 0 .. LIMIT-1
    int mode;       // 0 idle, 1 running, 2 paused
    bit exp_wrap;
`ifdef TICK_EDGE_DET_EN
    bit m_prev;
    bit m_pend;
`endif

    logic [15:0] dut_digits;
    logic [17:0] dut_out;
    assign dut_digits = {bus.oMinT, bus.oMinU, bus.oSecT, bus.oSecU};
    assign dut_out    = {dut_digits, bus.oRun, bus.oWrap};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_digits();
        int s, m;
        s = total % 60;
        m = total / 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [17:0] model_out();
        return {model_digits(), (mode == 1), exp_wrap};
    endfunction

    task automatic model_reset();
        total    = 0;
        mode     = 0;
        exp_wrap = 0;
`ifdef TICK_EDGE_DET_EN
        m_prev = 0;
        m_pend = 0;
`endif
    endtask

    task automatic model_update(input bit t, input bit s, input bit p, input bit c);
        bit evt;
`ifdef TICK_EDGE_DET_EN
        evt    = m_pend;
        m_pend = t & ~m_prev;
        m_prev = t;
`else
        evt = t;
`endif
        exp_wrap = 0;
        if (mode == 1) begin
            if (c) begin
                mode  = 0;
                total = 0;
            end else begin
                if (evt) begin
                    if (total == LIMIT - 1) begin
                        total    = 0;
                        exp_wrap = 1;
                    end else begin
                        total = total + 1;
                    end
                end
                if (p) mode = 2;
            end
        end else if (c) begin
            mode  = 0;
            total = 0;
        end else if (!p && s) begin
            mode = 1;
        end
    endtask

    // One clock cycle with the given strobes; the model advances on the
    // same edge and the full output vector is compared shortly after.
    task automatic step(input bit t, input bit s, input bit p, input bit c);
        @(negedge iclk);
        bus.iTick  = t;
        bus.iStart = s;
        bus.iStop  = p;
        bus.iClear = c;
        @(posedge iclk);
        model_update(t, s, p, c);
        #1;
        check("cycle", 32'(dut_out), 32'(model_out()));
    endtask

    // n isolated tick pulses, each followed by a quiet cycle so that the
    // edge-detect build sees every pulse and has finished counting it.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
    endtask

    // Reset asserted in the middle of the high clock phase; outputs must
    // clear before the next rising edge.
    task automatic do_reset();
        @(posedge iclk);
        #3;
        irst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async", 32'(dut_out), 32'(model_out()));
        check("rst_clear", 32'(dut_out), 32'h0);
        @(negedge iclk);
        bus.iTick  = 1'b0;
        bus.iStart = 1'b0;
        bus.iStop  = 1'b0;
        bus.iClear = 1'b0;
        irst_n     = 1'b1;
    endtask

    int wrap_seen;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        bus.iTick  = 1'b0;
        bus.iStart = 1'b0;
        bus.iStop  = 1'b0;
        bus.iClear = 1'b0;
        irst_n     = 1'b1;
        model_reset();

        // power-up reset
        #2 irst_n = 1'b0;
        #1;
        check("reset_out", 32'(dut_out), 32'h0);
        @(negedge iclk);
        @(negedge iclk);
        irst_n = 1'b1;

        // ticks without iStart are ignored
        tick_n(3);
        check("idle_hold", 32'(dut_digits), 32'h0000);
        check("idle_run", 32'(bus.oRun), 32'h0);

        // start, 10 ticks -> 00:10
        step(0, 1, 0, 0);
        tick_n(10);
        check("ten_sect", 32'(bus.oSecT), 32'h1);
        check("ten_secu", 32'(bus.oSecU), 32'h0);
        check("ten_run", 32'(bus.oRun), 32'h1);

        // 00:59 -> 01:00
        do_reset();
        step(0, 1, 0, 0);
        tick_n(59);
        check("t_0059", 32'(dut_digits), 32'h0059);
        step(1, 0, 0, 0);
`ifndef TICK_EDGE_DET_EN
        check("carry_lat", 32'(dut_digits), 32'h0100);
`endif
        step(0, 0, 0, 0);
        check("t_0100", 32'(dut_digits), 32'h0100);

        // 59:59 -> 00:00 with a single oWrap pulse
        do_reset();
        step(0, 1, 0, 0);
        tick_n(LIMIT - 1);
        check("t_5959", 32'(dut_digits), 32'h5959);
        wrap_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step((i == 0), 0, 0, 0);
            if (bus.oWrap) wrap_seen++;
        end
        check("wrap_cnt", 32'(wrap_seen), 32'd1);
        check("wrap_zero", 32'(dut_digits), 32'h0000);
        check("wrap_run", 32'(bus.oRun), 32'h1);

        // stop coinciding with tick at 00:05
        do_reset();
        step(0, 1, 0, 0);
        tick_n(5);
        check("t_0005", 32'(dut_digits), 32'h0005);
        step(1, 0, 1, 0);
`ifndef TICK_EDGE_DET_EN
        check("stop_tick", 32'(dut_digits), 32'h0006);
`endif
        check("stop_run", 32'(bus.oRun), 32'h0);
        tick_n(3);
`ifndef TICK_EDGE_DET_EN
        check("pause_hold", 32'(dut_digits), 32'h0006);
`endif
        step(0, 1, 0, 0);
        tick_n(1);
`ifndef TICK_EDGE_DET_EN
        check("resume", 32'(dut_digits), 32'h0007);
`endif
        check("resume_run", 32'(bus.oRun), 32'h1);

        // clear + stop + tick together at 03:27
        do_reset();
        step(0, 1, 0, 0);
        tick_n(207);
        check("t_0327", 32'(dut_digits), 32'h0327);
        step(1, 0, 1, 1);
        check("clr_zero", 32'(dut_digits), 32'h0000);
        check("clr_run", 32'(bus.oRun), 32'h0);
        check("clr_wrap", 32'(bus.oWrap), 32'h0);
        step(0, 0, 0, 0);
        check("clr_idle", 32'(dut_out), 32'h0);

        // asynchronous reset at 12:34
        do_reset();
        step(0, 1, 0, 0);
        tick_n(754);
        check("t_1234", 32'(dut_digits), 32'h1234);
        do_reset();
        tick_n(3);
        check("post_rst", 32'(dut_out), 32'h0);
        step(0, 1, 0, 0);
        tick_n(1);
        check("post_start", 32'(dut_digits), 32'h0001);

        // iTick held high for 5 cycles
        do_reset();
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
`ifdef TICK_EDGE_DET_EN
        check("held_tick", 32'(dut_digits), 32'h0001);
`else
        check("held_tick", 32'(dut_digits), 32'h0005);
`endif

        // randomized strobes against the model
        do_reset();
        step(0, 1, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 1) == 1,
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 49) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
